ama_riscv_mem_arb: RTL
======================

# ama_riscv_mem_arb

Shared backing-memory arbiter between the instruction cache and data cache miss/writeback ports. It merges three request channels into one memory request port: icache line read, dcache line read, and dcache line write. It keeps at most one transaction in flight and steers the single memory read response back to the cache that issued it. It sits directly below the core top-level, replacing the separate imem/dmem memory connections.

## Interface
- `AW`, 28: line address width (16-byte lines on a 32-bit byte address).
- `DW`, 128: line data width.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_imem_valid`, `req_imem_ready`, `req_imem_addr`  in/out/in  1/1/AW  icache line read request.
- `rsp_imem_valid`, `rsp_imem_ready`, `rsp_imem_data`  out/in/out  1/1/DW  icache read response.
- `req_dmem_r_valid`, `req_dmem_r_ready`, `req_dmem_r_addr`  in/out/in  1/1/AW  dcache line read request.
- `rsp_dmem_valid`, `rsp_dmem_ready`, `rsp_dmem_data`  out/in/out  1/1/DW  dcache read response.
- `req_dmem_w_valid`, `req_dmem_w_ready`, `req_dmem_w_addr`, `req_dmem_w_data`  in/out/in/in  1/1/AW/DW  dcache writeback request.
- `mem_req_valid`, `mem_req_ready`  out/in  1/1  memory request handshake.
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`  out  1/AW/DW  memory request payload; `mem_req_we` = 1 means write.
- `mem_rsp_valid`, `mem_rsp_ready`, `mem_rsp_data`  in/out/in  1/1/DW  memory read response.
- `arb_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Handshakes.** All channels use valid/ready. A transfer happens on a cycle where both valid and ready are high.
- **FSM states.** IDLE, ISSUE, WAIT_RD.
- **IDLE arbitration.** Each cycle, pick one winner among the pending valids.
  - The D-side candidate is `req_dmem_w` if its valid is high, otherwise `req_dmem_r`.
  - Write-before-read on the D side is mandatory; it guarantees eviction writeback precedes refill.
  - If both D and I are pending, the winner is chosen by the `prio_i` flag: `prio_i` = 1 grants I, 0 grants D.
  - If only one side is pending, that side wins and `prio_i` is ignored.
- **Grant.** The winner's `req_*_ready` is asserted combinationally in IDLE; all other readies stay 0.
  - On the grant handshake: latch addr, data and `we` into the `mem_req_*` registers, and latch owner (I or D) into a register.
  - `prio_i` updates: set to 1 after a D grant, cleared to 0 after an I grant.
  - Go to ISSUE.
- **ISSUE.**
  - `mem_req_valid` = 1, with the payload held stable until `mem_req_ready`.
  - On handshake: a write returns to IDLE; a read goes to WAIT_RD.
- **WAIT_RD.**
  - The owner's `rsp_*_valid` = `mem_rsp_valid`; its `rsp_*_data` = `mem_rsp_data`.
  - `mem_rsp_ready` = the owner's `rsp_*_ready`.
  - On handshake, go to IDLE.
  - The non-owner's `rsp_*_valid` = 0.
- **Stray responses.** `mem_rsp_ready` = 0 in IDLE and ISSUE; a `mem_rsp_valid` arriving then is not consumed.
- **Reset.** `rst` forces IDLE, `prio_i` = 0, owner = D, and `mem_req_*` registers = 0. An outstanding read is abandoned.
- **Output reset values.** All ready/valid outputs are 0, `mem_req_addr`/`mem_req_wdata` are 0, and `arb_busy` is 0. `req_*_ready` is gated low while `rst` is high.

## Timing
- **Request accept.** Accepted in cycle N (IDLE); `mem_req_valid` first high in N+1.
- **Write.** With `mem_req_ready` = 1 at N+1, back in IDLE at N+2. Minimum write-to-write spacing is 2 cycles.
- **Read.** Response forwarded combinationally (0-cycle) in the cycle `mem_rsp_valid` is high in WAIT_RD; back in IDLE the next cycle.
- **Boundary conditions.**
  - A new request arriving during ISSUE or WAIT_RD waits, valid held by the cache; no ready is asserted.
  - Simultaneous arrival of all three requests is served in this order: dmem_w, imem, dmem_r (with `prio_i` = 0 after reset).
  - Backpressure: `mem_req_ready` low for any number of cycles keeps the payload constant. `rsp_*_ready` low stalls WAIT_RD.
  - Starvation bound: with both sides continuously requesting, each side waits at most one foreign transaction.

## Test plan
- **Single icache read.**
  - Stimulus: `req_imem_addr` = 0x0000010, memory ready always, response data 0x…DEADBEEF two cycles after accept.
  - Required: `mem_req_we` = 0 and addr 0x0000010 at N+1; `rsp_imem_valid` carries 0x…DEADBEEF; `rsp_dmem_valid` stays 0.
- **Dcache eviction.**
  - Stimulus: `req_dmem_w` (addr 0x40, data 0xA5…) and `req_dmem_r` (addr 0x80) asserted together.
  - Required: write issued first with `mem_req_we` = 1; read of 0x80 issued only after the write handshake.
- **Contention fairness.**
  - Stimulus: imem and dmem_r valid continuously for 6 grants after reset.
  - Required: grant order D, I, D, I, D, I.
- **Backpressure.**
  - Stimulus: `mem_req_ready` low for 5 cycles, then `rsp_dmem_ready` low for 3 cycles.
  - Required: payload and `mem_req_valid` stable throughout; `mem_rsp_ready` = 0 while `rsp_dmem_ready` = 0; exactly one response delivered.
- **Reset mid-read.**
  - Stimulus: assert `rst` in WAIT_RD.
  - Required: all outputs 0 immediately (asynchronous); after release, the next imem request is granted normally with D-priority `prio_i` = 0.
- **Stray response in IDLE.**
  - Stimulus: `mem_rsp_valid` = 1 in IDLE.
  - Required: `mem_rsp_ready` = 0 and no `rsp_*_valid`.

Source files
------------

// File: rtl/ama_riscv_mem_arb_if.sv
// ama_riscv_mem_arb_if
// Bundles the three cache-side request channels, the two cache-side read
// response channels, the backing-memory request/response channels and the
// busy flag of the shared memory arbiter.
//   master : arbiter view (accepts cache requests, drives the memory request,
//            routes memory read data back to the caches)
//   slave  : environment view (the two caches plus the backing memory)
// Parameters: AW line address width, DW line data width.
interface ama_riscv_mem_arb_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  // icache line read
  logic          req_imem_valid;
  logic          req_imem_ready;
  logic [AW-1:0] req_imem_addr;
  logic          rsp_imem_valid;
  logic          rsp_imem_ready;
  logic [DW-1:0] rsp_imem_data;
  // dcache line read
  logic          req_dmem_r_valid;
  logic          req_dmem_r_ready;
  logic [AW-1:0] req_dmem_r_addr;
  logic          rsp_dmem_valid;
  logic          rsp_dmem_ready;
  logic [DW-1:0] rsp_dmem_data;
  // dcache writeback
  logic          req_dmem_w_valid;
  logic          req_dmem_w_ready;
  logic [AW-1:0] req_dmem_w_addr;
  logic [DW-1:0] req_dmem_w_data;
  // backing memory
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic          mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  // status
  logic          arb_busy;

  modport master (
    input  req_imem_valid, req_imem_addr, rsp_imem_ready,
    output req_imem_ready, rsp_imem_valid, rsp_imem_data,
    input  req_dmem_r_valid, req_dmem_r_addr, rsp_dmem_ready,
    output req_dmem_r_ready, rsp_dmem_valid, rsp_dmem_data,
    input  req_dmem_w_valid, req_dmem_w_addr, req_dmem_w_data,
    output req_dmem_w_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output mem_rsp_ready,
    output arb_busy
  );

  modport slave (
    output req_imem_valid, req_imem_addr, rsp_imem_ready,
    input  req_imem_ready, rsp_imem_valid, rsp_imem_data,
    output req_dmem_r_valid, req_dmem_r_addr, rsp_dmem_ready,
    input  req_dmem_r_ready, rsp_dmem_valid, rsp_dmem_data,
    output req_dmem_w_valid, req_dmem_w_addr, req_dmem_w_data,
    input  req_dmem_w_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  mem_rsp_ready,
    input  arb_busy
  );
endinterface

// File: rtl/ama_riscv_mem_arb.sv
// ama_riscv_mem_arb
// Shares one backing-memory port between the icache line-read channel and
// the dcache line-read / writeback channels. One transaction is in flight
// at a time; the read response is steered to the cache that issued it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ama_riscv_mem_arb_if.master (cache requests/responses, memory
//        request/response, arb_busy)
module ama_riscv_mem_arb #(
  parameter int AW = 28,
  parameter int DW = 128
) (
  input  logic                clk,
  input  logic                rst,
  ama_riscv_mem_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          prio_i_r;    // 1: I side wins the next I/D tie
  logic          owner_i_r;   // 1: in-flight read belongs to the icache
  logic          mem_req_we_r;
  logic [AW-1:0] mem_req_addr_r;
  logic [DW-1:0] mem_req_wdata_r;

  logic grant_i_s;
  logic grant_dw_s;
  logic grant_dr_s;
  logic accept_s;
  logic rsp_i_sel_s;
  logic rsp_d_sel_s;
  logic mem_rsp_ready_s;

  // IDLE arbitration: D side offers the writeback ahead of its refill so an
  // eviction always lands in memory before the line is re-read.
  always_comb begin
    grant_i_s  = 1'b0;
    grant_dw_s = 1'b0;
    grant_dr_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (bus.req_imem_valid &&
          (!(bus.req_dmem_w_valid || bus.req_dmem_r_valid) || prio_i_r)) begin
        grant_i_s = 1'b1;
      end else if (bus.req_dmem_w_valid) begin
        grant_dw_s = 1'b1;
      end else if (bus.req_dmem_r_valid) begin
        grant_dr_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
    end
    // A ready is only raised toward a valid requester, so a grant is a handshake.
    accept_s = grant_i_s || grant_dw_s || grant_dr_s;
  end

  // Response steering and next-state decode.
  always_comb begin
    rsp_i_sel_s     = (state_r == WAIT_RD) && owner_i_r;
    rsp_d_sel_s     = (state_r == WAIT_RD) && !owner_i_r;
    mem_rsp_ready_s = (rsp_i_sel_s && bus.rsp_imem_ready) ||
                      (rsp_d_sel_s && bus.rsp_dmem_ready);
    state_nxt_s     = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_nxt_s = mem_req_we_r ? IDLE : WAIT_RD;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_RD: begin
        if (bus.mem_rsp_valid && mem_rsp_ready_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request payload, owner and priority captured on the grant handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_i_r        <= 1'b0;
      owner_i_r       <= 1'b0;
      mem_req_we_r    <= 1'b0;
      mem_req_addr_r  <= {AW{1'b0}};
      mem_req_wdata_r <= {DW{1'b0}};
    end else if (accept_s) begin
      owner_i_r       <= grant_i_s;
      prio_i_r        <= !grant_i_s;
      mem_req_we_r    <= grant_dw_s;
      mem_req_addr_r  <= grant_i_s  ? bus.req_imem_addr :
                         grant_dw_s ? bus.req_dmem_w_addr : bus.req_dmem_r_addr;
      mem_req_wdata_r <= grant_dw_s ? bus.req_dmem_w_data : {DW{1'b0}};
    end
  end

  assign bus.req_imem_ready   = grant_i_s;
  assign bus.req_dmem_w_ready = grant_dw_s;
  assign bus.req_dmem_r_ready = grant_dr_s;

  assign bus.mem_req_valid = (state_r == ISSUE);
  assign bus.mem_req_we    = mem_req_we_r;
  assign bus.mem_req_addr  = mem_req_addr_r;
  assign bus.mem_req_wdata = mem_req_wdata_r;
  assign bus.mem_rsp_ready = mem_rsp_ready_s;

  assign bus.rsp_imem_valid = rsp_i_sel_s && bus.mem_rsp_valid;
  assign bus.rsp_dmem_valid = rsp_d_sel_s && bus.mem_rsp_valid;
  assign bus.rsp_imem_data  = rsp_i_sel_s ? bus.mem_rsp_data : {DW{1'b0}};
  assign bus.rsp_dmem_data  = rsp_d_sel_s ? bus.mem_rsp_data : {DW{1'b0}};

  assign bus.arb_busy = (state_r != IDLE);

endmodule
